// File: rtl/adc_pkg.sv
// adc_pkg: constants shared by the ADC frame packer and its related blocks.
//   ADC_NCH      channels per frame
//   ADC_SW       sample width in bits
//   ADC_NSLOT    sample slots per frame (two sides per channel)
//   ADC_FRAME_W  width of one packed frame
//   slot_offset  bit offset of slot k inside a packed frame
package adc_pkg;

  localparam int ADC_NCH     = 24;
  localparam int ADC_SW      = 18;
  localparam int ADC_NSLOT   = 2 * ADC_NCH;
  localparam int ADC_FRAME_W = ADC_NSLOT * ADC_SW;

  // Slot k occupies bits [k*sw +: sw]; slot 0 (channel 1a) sits at the LSBs.
  function automatic int slot_offset(input int k, input int sw);
    return k * sw;
  endfunction

endpackage

// File: rtl/adc_slot_counter.sv
// adc_slot_counter: modulo-NSLOT slot index for the frame packer.
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the count to 0
//   inc       a sample was transferred this cycle
//   sof_load  the transferred sample is a frame start; the count becomes 1
//   cnt       slot the next transferred sample will occupy
//   last      cnt is the final slot of the frame (NSLOT-1)
module adc_slot_counter
  import adc_pkg::*;
#(
  parameter int NSLOT = ADC_NSLOT,
  localparam int CW   = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          sof_load,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(NSLOT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      // A frame start always lands in slot 0, so the next slot is 1 whether
      // or not the counter was already aligned.
      if (sof_load)  cnt <= CW'(1);
      else if (last) cnt <= '0;
      else           cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: collects 2*NCH ADC samples (1a,1b,...,NCHa,NCHb) into one
// wide frame word and hands it downstream with a valid/ready handshake.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   s_valid    input sample valid
//   s_ready    packer accepts a sample this cycle
//   s_data     ADC sample
//   s_sof      sample is slot 0 (channel 1a) of a frame
//   m_data     packed frame, slot k at bits [k*SW +: SW]
//   m_valid    m_data holds a complete frame
//   m_ready    downstream accepts the frame
//   sync_err   one-cycle pulse after a frame boundary is resynchronised
//   frame_cnt  frames completed, wrapping
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int NCH    = ADC_NCH,
  parameter int SW     = ADC_SW,
  parameter int FCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SW-1:0]         s_data,
  input  logic                  s_sof,
  output logic [2*NCH*SW-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  sync_err,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam int NSLOT = 2 * NCH;
  localparam int FW    = NSLOT * SW;
  localparam int CW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic [CW-1:0] slot;
  logic          last;
  logic [CW-1:0] wr_slot;
  logic [FW-1:0] acc;
  logic [FW-1:0] acc_next;
  logic          xfer;
  logic          resync;
  logic          frame_done;

  // Only the final slot can be stalled: it is the one transfer that must
  // move the accumulator into m_data, which is still occupied. Everything
  // else keeps streaming into the accumulator. Depends on registered state,
  // rst and m_ready only, never on s_valid.
  assign s_ready    = !rst && !(last && m_valid && !m_ready);
  assign xfer       = s_valid && s_ready;
  assign resync     = xfer && s_sof && (slot != '0);
  // A frame start arriving at the last slot is a resync, not a completion.
  assign frame_done = xfer && !s_sof && last;
  assign wr_slot    = s_sof ? '0 : slot;

  adc_slot_counter #(
    .NSLOT (NSLOT)
  ) u_slot_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (xfer),
    .sof_load (s_sof),
    .cnt      (slot),
    .last     (last)
  );

  // NOTE: acc_next gets a full default before the conditional slot write;
  // without it this block would infer latches.
  always_comb begin
    // A resync throws away the partial frame so no stale slot can leak
    // into the next delivered frame.
    acc_next = resync ? '0 : acc;
    for (int k = 0; k < NSLOT; k++) begin
      if (xfer && (wr_slot == CW'(k))) begin
        acc_next[slot_offset(k, SW) +: SW] = s_data;
      end
    end
  end

  // NOTE: the accumulator and output frame are plain flops, not a memory,
  // so they can all be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      acc      <= acc_next;
      sync_err <= resync;
      if (frame_done) begin
        // Uses acc_next so the slot being written this cycle is included;
        // also covers a completion in the same cycle as an output handshake.
        m_data    <= acc_next;
        m_valid   <= 1'b1;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: scoreboard bench for adc_frame_packer. A reference
// model built from the frame-packing rules predicts every frame when its
// last slot is driven and pushes it to a queue; each output handshake pops
// and compares. Handshake outputs are checked every cycle against the model.
// A second, tiny instance (one channel, 4-bit frame counter) exercises the
// frame counter wrap within a short run.
module tb_adc_frame_packer;
  import adc_pkg::*;

  localparam int NCH = ADC_NCH;
  localparam int SW  = ADC_SW;
  localparam int NS  = 2 * NCH;
  localparam int FW  = ADC_FRAME_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic [FW-1:0] m_data;
  logic          m_valid;
  logic          sync_err;
  logic [15:0]   frame_cnt;

  logic          w_s_valid = 1'b0;
  logic          w_s_sof = 1'b0;
  logic [SW-1:0] w_s_data = '0;
  logic          w_m_ready = 1'b1;
  logic          w_s_ready;
  logic [2*SW-1:0] w_m_data;
  logic          w_m_valid;
  logic          w_sync_err;
  logic [3:0]    w_frame_cnt;

  always #5 clk = ~clk;

  adc_frame_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .sync_err  (sync_err),
    .frame_cnt (frame_cnt)
  );

  adc_frame_packer #(
    .NCH    (1),
    .SW     (SW),
    .FCNT_W (4)
  ) dut_wrap (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (w_s_valid),
    .s_ready   (w_s_ready),
    .s_data    (w_s_data),
    .s_sof     (w_s_sof),
    .m_data    (w_m_data),
    .m_valid   (w_m_valid),
    .m_ready   (w_m_ready),
    .sync_err  (w_sync_err),
    .frame_cnt (w_frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int            exp_cnt;
  logic [FW-1:0] exp_acc;
  logic          exp_mv;
  logic          exp_se;
  logic [15:0]   exp_fc;
  logic [FW-1:0] sb[$];

  int n_se_seen  = 0;
  int n_mv_seen  = 0;
  int n_rdy_low  = 0;

  task automatic model_reset();
    exp_cnt = 0;
    exp_acc = '0;
    exp_mv  = 1'b0;
    exp_se  = 1'b0;
    exp_fc  = '0;
    sb.delete();
  endtask

  // One clock: check pre-edge outputs, advance the model, cross the edge.
  task automatic cycle(output logic accepted);
    logic          exp_rdy;
    logic          hs_out;
    logic          done;
    logic          new_se;
    logic [FW-1:0] want;
    #1;
    exp_rdy = !rst && !(exp_cnt == NS - 1 && exp_mv && !m_ready);
    check("s_ready", s_ready, exp_rdy);
    check("m_valid", m_valid, exp_mv);
    check("sync_err", sync_err, exp_se);
    check("frame_cnt", frame_cnt, exp_fc);
    if (sync_err) n_se_seen++;
    if (m_valid) n_mv_seen++;
    if (!s_ready && !rst) n_rdy_low++;

    accepted = s_valid && exp_rdy;
    hs_out   = exp_mv && m_ready;
    if (hs_out) begin
      if (sb.size() == 0) begin
        check("sb_underflow", m_valid, 1'b0);
      end else begin
        want = sb.pop_front();
        check("m_data", m_data, want);
      end
    end

    done   = 1'b0;
    new_se = 1'b0;
    if (accepted) begin
      if (s_sof && exp_cnt != 0) begin
        new_se  = 1'b1;
        exp_acc = '0;
        exp_acc[SW-1:0] = s_data;
        exp_cnt = 1;
      end else begin
        exp_acc[exp_cnt*SW +: SW] = s_data;
        if (exp_cnt == NS - 1) begin
          done = 1'b1;
          sb.push_back(exp_acc);
          exp_cnt = 0;
        end else begin
          exp_cnt++;
        end
      end
    end
    if (done) begin
      exp_mv = 1'b1;
      exp_fc++;
    end else if (hs_out) begin
      exp_mv = 1'b0;
    end
    exp_se = new_se;
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    for (int i = 0; i < n; i++) cycle(a);
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [SW-1:0] d, input logic sof);
    logic a;
    int   t;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    a = 1'b0;
    t = 0;
    while (!a && t < 50) begin
      cycle(a);
      t++;
    end
    if (!a) check("send_timeout", SW'(t), '0);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  // Slots k0..k1 with data base+k; s_sof on slot 0.
  task automatic send_range(input int base, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) send(SW'(base + k), k == 0);
  endtask

  task automatic do_reset(input int n);
    logic a;
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle(a);
    check("rst_m_data", m_data, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_frame_cnt", frame_cnt, '0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("s_ready_after_rst", s_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mv0;
    int se0;
    int rl0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(3);

    // Single frame, sample k = k+1, consumer always ready
    m_ready = 1'b1;
    mv0 = n_mv_seen;
    send_range(1, 0, NS - 1);
    check("f1_slot0", m_data[17:0], 18'd1);
    check("f1_slot1", m_data[35:18], 18'd2);
    check("f1_slot47", m_data[863:846], 18'd48);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    idle(3);
    check("f1_valid_cycles", n_mv_seen - mv0, 1);

    // Back-pressure: frame 1 held, frame 2 stalls at its last slot
    m_ready = 1'b0;
    send_range(100, 0, NS - 1);
    send_range(200, 0, NS - 2);
    begin
      logic a;
      s_valid = 1'b1;
      s_data  = SW'(200 + NS - 1);
      s_sof   = 1'b0;
      for (int i = 0; i < 4; i++) cycle(a);
      check("bp_ready_low", s_ready, 1'b0);
      check("bp_hold_frame1", m_data[17:0], 18'd100);
    end
    m_ready = 1'b1;
    send(SW'(200 + NS - 1), 1'b0);
    idle(3);
    check("bp_drained", sb.size(), 0);

    // Resync after 10 samples
    se0 = n_se_seen;
    send_range(300, 0, 9);
    send(18'h3FFFF, 1'b1);
    send_range(400, 1, NS - 1);
    check("rs_slot0", m_data[17:0], 18'h3FFFF);
    check("rs_slot9", m_data[9*SW +: SW], 18'd409);
    idle(3);
    check("rs_sync_pulses", n_se_seen - se0, 1);

    // Three back-to-back frames from reset
    do_reset(2);
    mv0 = n_mv_seen;
    rl0 = n_rdy_low;
    send_range(1000, 0, NS - 1);
    send_range(2000, 0, NS - 1);
    send_range(3000, 0, NS - 1);
    idle(2);
    check("stream_valid_cycles", n_mv_seen - mv0, 3);
    check("stream_ready_drops", n_rdy_low - rl0, 0);
    check("stream_frame_cnt", frame_cnt, 16'd3);

    // Reset in the middle of a frame
    send_range(500, 0, 19);
    s_valid = 1'b1;
    do_reset(2);
    s_valid = 1'b0;
    send_range(600, 0, NS - 1);
    idle(2);
    check("midrst_frame_cnt", frame_cnt, 16'd1);
    check("midrst_drained", sb.size(), 0);

    // Frame counter wrap on the one-channel instance (4-bit counter)
    check("wrap_start", w_frame_cnt, 4'd0);
    for (int i = 0; i < 32; i++) begin
      w_s_valid = 1'b1;
      w_s_sof   = (i % 2 == 0);
      w_s_data  = SW'(i);
      #1;
      check("wrap_ready", w_s_ready, 1'b1);
      @(posedge clk);
      #1;
      if (i == 29) check("wrap_pre", w_frame_cnt, 4'd15);
    end
    w_s_valid = 1'b0;
    check("wrap_zero", w_frame_cnt, 4'd0);
    check("wrap_valid", w_m_valid, 1'b1);
    check("wrap_data", w_m_data, {18'd31, 18'd30});
    check("wrap_sync", w_sync_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 Parameter NCH, default 24: number of ADC channels per frame.
REQ-002 Parameter SW, default 18: sample width in bits.
REQ-003 Port clk, input, 1: sole clock; all logic is rising-edge clocked.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port s_valid, input, 1: the sample on s_data/s_sof is valid.
REQ-006 Port s_ready, output, 1: the packer accepts a sample this cycle.
REQ-007 Port s_data, input, SW: ADC sample.
REQ-008 Port s_sof, input, 1: this sample is channel 1a, the first slot of a frame.
REQ-009 Port m_data, output, 2*NCH*SW (864): packed frame.
REQ-010 Port m_valid, output, 1: m_data holds a complete frame.
REQ-011 Port m_ready, input, 1: the downstream consumer accepts the frame.
REQ-012 Port sync_err, output, 1: one-cycle pulse when a frame boundary is resynchronised.
REQ-013 Port frame_cnt, output, 16: count of frames delivered, wrapping at 65535 -> 0.

Function
REQ-014 A transfer occurs when s_valid and s_ready are both high in the same cycle.
REQ-015 Samples arrive in slot order 1a,1b,2a,2b,...,24a,24b.
REQ-016 Slot index k runs 0..2*NCH-1: channel n side a is k=2(n-1); channel n side b is k=2(n-1)+1.
REQ-017 A transferred sample is written to accumulation register bits [SW*k+SW-1 : SW*k]; all other bits are unchanged.
REQ-018 The slot counter increments on each transfer.
REQ-019 The slot counter wraps to 0 after slot 2*NCH-1 (47).
REQ-020 Transfer with s_sof=1 and counter!=0: the sample is written to slot 0, the counter becomes 1, sync_err pulses next cycle, and the partial frame is discarded.
REQ-021 Transfer with s_sof=1 and counter=0: normal behaviour, no sync_err.
REQ-022 Transfer with s_sof=0 and counter=0: accepted as slot 0, no error.
REQ-023 Transfer into slot 47 (frame complete) loads the full accumulation register, including the slot-47 sample, into the m_data register, sets m_valid on the next cycle, and increments frame_cnt in the same cycle m_valid rises.
REQ-024 m_valid and m_data stay stable until m_valid and m_ready are both high; m_valid then clears on the next cycle unless a new frame completes in that same cycle.
REQ-025 s_ready is low only when the counter is 47, m_valid=1 and m_ready=0; this back-pressures the last slot and never drops data.
REQ-026 Simultaneous slot-47 transfer and m_valid&m_ready handshake: the new frame loads and m_valid stays high; throughput is one frame per 48 transfers with no bubble.
REQ-027 Latency from the slot-47 transfer to m_valid is 1 cycle.
REQ-028 s_ready is purely a function of registered state and m_ready; there is no combinational path from s_valid to s_ready.

Reset
REQ-029 While rst=1: the slot counter is 0, m_valid=0, m_data=0, the accumulation register is 0, sync_err=0, frame_cnt=0 and s_ready=0.
REQ-030 s_ready rises in the first cycle after rst deasserts.
REQ-031 Reset mid-frame discards the partial frame and any unconsumed m_data without raising sync_err.

Structure
REQ-032 Package adc_pkg shall hold ADC_NCH=24, ADC_SW=18, ADC_FRAME_W=864 and a slot-offset function (k*SW); adc_data_slicer-compatible users share it.
REQ-033 One sub-module, adc_slot_counter, shall contain the modulo-2*NCH counter with an increment enable, a sof load-to-1 input and a wrap/last flag.
REQ-034 All other logic is flat in adc_frame_packer; no memories are inferred, only registers.

Verification
REQ-035 48 back-to-back transfers, sample k = k+1, s_sof on k=0, m_ready=1 -> m_valid for 1 cycle; m_data[17:0]=1, [35:18]=2, [863:846]=48; frame_cnt=1.
REQ-036 Same frame with m_ready=0 held, then a second frame streamed -> s_ready drops at slot 47 of frame 2; frame 1 stays on m_data; releasing m_ready delivers frame 1 then frame 2 intact.
REQ-037 After 10 samples, s_sof with data 0x3FFFF -> sync_err pulses once; the next completed frame has m_data[17:0]=0x3FFFF and no stale slots from the partial frame.
REQ-038 Continuous stream with m_ready=1 for 3 frames -> m_valid is high exactly one cycle per 48 transfers, s_ready never drops, frame_cnt=3.
REQ-039 rst asserted at slot 20, then a full frame -> m_valid=0 during reset, the following frame is correct, and frame_cnt=1.
REQ-040 Preload frame_cnt to 65535 via frames, then one more frame -> frame_cnt wraps to 0.
